// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH flip-flops whose per-bit behaviour (D, SR, JK or T) is picked at runtime.
// S=R=1 requests in SR mode resolve per SR_POLICY and are flagged and counted.
module multimode_ff_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 SR_POLICY = 0,
    parameter logic [WIDTH-1:0]   RST_VAL   = {WIDTH{1'b0}},
    parameter int                 ERR_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             illegal,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_SR = 2'b01,
        MODE_JK = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic             illegal_q, illegal_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic [WIDTH-1:0] sr_both;
    logic [WIDTH-1:0] sr_base;

    assign mode_s  = mode_e'(mode);
    assign sr_both = a & b;
    assign hit     = en && (mode_s == MODE_SR) && (|sr_both);

    // Bits with exactly one of S/R asserted; S=R=1 bits hold here and get the policy applied below.
    assign sr_base = (q_q & ~(~a & b)) | (a & ~b);

    always_comb begin
        q_d       = q_q;
        illegal_d = hit;
        cnt_d     = cnt_q;

        if (en) begin
            case (mode_s)
                MODE_D:  q_d = a;
                MODE_SR: begin
                    q_d = sr_base;
                    if (SR_POLICY == 1) begin
                        q_d = sr_base | sr_both;
                    end else if (SR_POLICY == 2) begin
                        q_d = sr_base & ~sr_both;
                    end
                end
                MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
                MODE_T:  q_d = q_q ^ a;
                default: q_d = q_q;
            endcase
        end

        // Clearing takes effect before a same-edge event is counted.
        if (err_clr) begin
            cnt_d = hit ? ERR_W'(1) : '0;
        end else if (hit && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RST_VAL;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign illegal = illegal_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench for multimode_ff_bank: three instances, one per SR_POLICY value,
// share stimulus; the driver queues hand-computed results and a monitor checks them.
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       err_clr = 1'b0;

    logic [7:0] q0, q1, q2, qn0, qn1, qn2;
    logic       ill0, ill1, ill2;
    logic [3:0] cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] q2;
        logic       ill;
        logic [3:0] cnt;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    multimode_ff_bank #(.WIDTH(8), .SR_POLICY(0), .ERR_W(4)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q0), .qn(qn0), .illegal(ill0), .err_cnt(cnt0));
    multimode_ff_bank #(.WIDTH(8), .SR_POLICY(1), .ERR_W(4)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q1), .qn(qn1), .illegal(ill1), .err_cnt(cnt1));
    multimode_ff_bank #(.WIDTH(8), .SR_POLICY(2), .ERR_W(4)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
        .q(q2), .qn(qn2), .illegal(ill2), .err_cnt(cnt2));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("q_p0", q0, mon_e.q0);
            chk("q_p1", q1, mon_e.q1);
            chk("q_p2", q2, mon_e.q2);
            chk("qn_p0", qn0, ~mon_e.q0);
            chk("qn_p1", qn1, ~mon_e.q1);
            chk("qn_p2", qn2, ~mon_e.q2);
            chk("illegal_p0", {7'd0, ill0}, {7'd0, mon_e.ill});
            chk("illegal_p1", {7'd0, ill1}, {7'd0, mon_e.ill});
            chk("illegal_p2", {7'd0, ill2}, {7'd0, mon_e.ill});
            chk("err_cnt_p0", {4'd0, cnt0}, {4'd0, mon_e.cnt});
            chk("err_cnt_p1", {4'd0, cnt1}, {4'd0, mon_e.cnt});
            chk("err_cnt_p2", {4'd0, cnt2}, {4'd0, mon_e.cnt});
        end
    end

    // Apply one cycle of stimulus and queue what every instance must show after the next edge.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] av, input logic [7:0] bv, input logic c,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input logic eill, input logic [3:0] ecnt);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; mode = m; a = av; b = bv; err_clr = c;
        x.q0 = e0; x.q1 = e1; x.q2 = e2; x.ill = eill; x.cnt = ecnt;
        sbq.push_back(x);
    endtask

    localparam logic [1:0] D = 2'b00, SR = 2'b01, JK = 2'b10, T = 2'b11;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and D mode
        step(1, 1, D,  8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 4'd0);
        step(0, 1, D,  8'hA5, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 4'd0);
        step(0, 0, D,  8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 0, 4'd0);
        step(0, 1, D,  8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 4'd0);
        // SR with S=R=1 on bits 5:4: hold / set / clear per policy
        step(0, 1, SR, 8'hF0, 8'h3C, 0, 8'hC3, 8'hF3, 8'hC3, 1, 4'd1);
        step(0, 0, SR, 8'h00, 8'h00, 0, 8'hC3, 8'hF3, 8'hC3, 0, 4'd1);
        // Gated illegal request is neither applied, flagged nor counted
        step(0, 0, SR, 8'hFF, 8'hFF, 0, 8'hC3, 8'hF3, 8'hC3, 0, 4'd1);
        // Legal SR set/clear only
        step(0, 1, SR, 8'h30, 8'h03, 0, 8'hF0, 8'hF0, 8'hF0, 0, 4'd1);
        // JK and T
        step(0, 1, D,  8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 4'd1);
        step(0, 1, JK, 8'hFF, 8'hFF, 0, 8'hF0, 8'hF0, 8'hF0, 0, 4'd1);
        step(0, 1, JK, 8'hC0, 8'h30, 0, 8'hC0, 8'hC0, 8'hC0, 0, 4'd1);
        step(0, 1, D,  8'hF0, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 0, 4'd1);
        step(0, 1, T,  8'h81, 8'hFF, 0, 8'h71, 8'h71, 8'h71, 0, 4'd1);
        step(0, 1, T,  8'h00, 8'hFF, 0, 8'h71, 8'h71, 8'h71, 0, 4'd1);
        // Counter: clear alone while disabled, then saturate
        step(0, 0, T,  8'hFF, 8'h00, 1, 8'h71, 8'h71, 8'h71, 0, 4'd0);
        step(0, 1, SR, 8'h01, 8'h01, 0, 8'h71, 8'h71, 8'h70, 1, 4'd1);
        for (int i = 2; i <= 20; i++) begin
            step(0, 1, SR, 8'h01, 8'h01, 0, 8'h71, 8'h71, 8'h70, 1,
                 (i >= 15) ? 4'd15 : 4'(i));
        end
        step(0, 1, SR, 8'h01, 8'h01, 1, 8'h71, 8'h71, 8'h70, 1, 4'd1);
        step(0, 1, D,  8'h55, 8'h00, 1, 8'h55, 8'h55, 8'h55, 0, 4'd0);
        // Mid-stream reset during a toggle stream, including a concurrent illegal request
        step(0, 1, SR, 8'h80, 8'h80, 0, 8'h55, 8'hD5, 8'h55, 1, 4'd1);
        step(0, 1, D,  8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 4'd1);
        step(0, 1, T,  8'hFF, 8'h00, 0, 8'hFF, 8'hFF, 8'hFF, 0, 4'd1);
        step(0, 1, T,  8'h0F, 8'h00, 0, 8'hF0, 8'hF0, 8'hF0, 0, 4'd1);
        step(1, 1, T,  8'h0F, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 4'd0);
        step(0, 1, T,  8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 0, 4'd0);
        step(0, 1, SR, 8'h02, 8'h02, 0, 8'h0F, 8'h0F, 8'h0D, 1, 4'd1);
        step(1, 1, SR, 8'hFF, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 0, 4'd0);
        step(0, 1, T,  8'h3C, 8'h00, 0, 8'h3C, 8'h3C, 8'h3C, 0, 4'd0);

        @(posedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
